// File: rtl/hms_timekeeper.sv
// hms_timekeeper: BCD hours/minutes/seconds clock with a button-driven set mode
module hms_timekeeper #(
    parameter int INIT_HOUR = 0,
    parameter int INIT_MIN  = 0,
    parameter int INIT_SEC  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] set_field,
    output logic       day_pulse
);
    typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10, SET_SEC = 2'b11} state_t;

    localparam logic [7:0] INIT_H = 8'(((INIT_HOUR / 10) << 4) | (INIT_HOUR % 10));
    localparam logic [7:0] INIT_M = 8'(((INIT_MIN / 10) << 4) | (INIT_MIN % 10));
    localparam logic [7:0] INIT_S = 8'(((INIT_SEC / 10) << 4) | (INIT_SEC % 10));

    state_t     state, next_state;
    logic [7:0] hour_nx, min_nx, sec_nx;
    logic       day_nx;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? ((v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0})
                                : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc24(input logic [7:0] v);
        return (v == 8'h23) ? 8'h00
             : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign set_field = state;

    // Next state and next time: ticks ripple in RUN, inc_btn edits one field in set states
    always_comb begin
        next_state = mode_btn ? state_t'(state + 2'd1) : state;
        hour_nx    = hour_bcd;
        min_nx     = min_bcd;
        sec_nx     = sec_bcd;
        day_nx     = 1'b0;
        if (state == RUN && sec_tick) begin
            sec_nx = inc60(sec_bcd);
            if (sec_bcd == 8'h59) begin
                min_nx = inc60(min_bcd);
                if (min_bcd == 8'h59) begin
                    hour_nx = inc24(hour_bcd);
                    day_nx  = (hour_bcd == 8'h23);
                end
            end
        end else if (state != RUN && inc_btn && !mode_btn) begin
            hour_nx = (state == SET_HOUR) ? inc24(hour_bcd) : hour_bcd;
            min_nx  = (state == SET_MIN)  ? inc60(min_bcd)  : min_bcd;
            sec_nx  = (state == SET_SEC)  ? 8'h00           : sec_bcd;
        end
    end

    // State and time registers with synchronous active-low reset to the INIT values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            hour_bcd  <= INIT_H;
            min_bcd   <= INIT_M;
            sec_bcd   <= INIT_S;
            day_pulse <= 1'b0;
        end else begin
            state     <= next_state;
            hour_bcd  <= hour_nx;
            min_bcd   <= min_nx;
            sec_bcd   <= sec_nx;
            day_pulse <= day_nx;
        end
    end
endmodule

// File: tb/tb_hms_timekeeper.sv
// tb_hms_timekeeper: directed scoreboard bench for hms_timekeeper
module tb_hms_timekeeper;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sec_tick = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [1:0] set_field;
    logic       day_pulse;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [26:0] val;
    } exp_t;
    exp_t sb[$];

    hms_timekeeper #(.INIT_HOUR(12), .INIT_MIN(34), .INIT_SEC(56)) dut (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .set_field(set_field), .day_pulse(day_pulse)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic t, input logic m, input logic i);
        @(negedge clk);
        rst_n = r; sec_tick = t; mode_btn = m; inc_btn = i;
        @(posedge clk);
        #1;
        rst_n = 1'b1; sec_tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    endtask

    task automatic run(input int n, input logic t, input logic m, input logic i);
        for (int k = 0; k < n; k++) cyc(1'b1, t, m, i);
    endtask

    task automatic step(input string tag, input logic r, input logic t, input logic m, input logic i,
                        input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                        input logic [1:0] ef, input logic ed);
        exp_t e;
        logic [26:0] obs;
        sb.push_back('{tag, {eh, em, es, ef, ed}});
        cyc(r, t, m, i);
        e = sb.pop_front();
        obs = {hour_bcd, min_bcd, sec_bcd, set_field, day_pulse};
        n_chk++;
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed h=%h m=%h s=%h f=%b d=%b expected h=%h m=%h s=%h f=%b d=%b",
                   e.tag, obs[26:19], obs[18:11], obs[10:3], obs[2:1], obs[0],
                   e.val[26:19], e.val[18:11], e.val[10:3], e.val[2:1], e.val[0]);
        end
    endtask

    initial begin
        step("rst_hold0", 0, 1, 0, 0, 8'h12, 8'h34, 8'h56, 2'b00, 0);
        step("rst_hold1", 0, 1, 1, 1, 8'h12, 8'h34, 8'h56, 2'b00, 0);
        step("idle",      1, 0, 0, 0, 8'h12, 8'h34, 8'h56, 2'b00, 0);
        step("run_inc_ign", 1, 0, 0, 1, 8'h12, 8'h34, 8'h56, 2'b00, 0);
        step("to_set_h",  1, 0, 1, 0, 8'h12, 8'h34, 8'h56, 2'b01, 0);
        run(10, 0, 0, 1);
        step("hr_23",     1, 0, 0, 1, 8'h23, 8'h34, 8'h56, 2'b01, 0);
        step("hr_wrap",   1, 0, 0, 1, 8'h00, 8'h34, 8'h56, 2'b01, 0);
        step("to_set_m",  1, 0, 1, 0, 8'h00, 8'h34, 8'h56, 2'b10, 0);
        run(25, 0, 0, 1);
        step("min_wrap0", 1, 0, 0, 1, 8'h00, 8'h00, 8'h56, 2'b10, 0);
        step("to_set_s",  1, 0, 1, 0, 8'h00, 8'h00, 8'h56, 2'b11, 0);
        step("sec_clr",   1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'b11, 0);
        step("to_run",    1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 2'b00, 0);
        run(58, 1, 0, 0);
        step("sec_59",    1, 1, 0, 0, 8'h00, 8'h00, 8'h59, 2'b00, 0);
        step("min_carry", 1, 1, 0, 0, 8'h00, 8'h01, 8'h00, 2'b00, 0);
        cyc(1, 0, 1, 0);
        run(9, 0, 0, 1);
        step("set_09",    1, 0, 1, 0, 8'h09, 8'h01, 8'h00, 2'b10, 0);
        run(58, 0, 0, 1);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        run(59, 1, 0, 0);
        step("hr_carry10", 1, 1, 0, 0, 8'h10, 8'h00, 8'h00, 2'b00, 0);
        cyc(1, 0, 1, 0);
        run(13, 0, 0, 1);
        cyc(1, 0, 1, 0);
        run(59, 0, 0, 1);
        cyc(1, 0, 1, 0);
        step("at_235900", 1, 0, 1, 0, 8'h23, 8'h59, 8'h00, 2'b00, 0);
        run(59, 1, 0, 0);
        step("day_roll",  1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 1);
        step("day_clear", 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 0);
        step("tick_01",   1, 1, 0, 0, 8'h00, 8'h00, 8'h01, 2'b00, 0);
        cyc(1, 0, 1, 0);
        run(22, 0, 0, 1);
        cyc(1, 0, 1, 0);
        run(58, 0, 0, 1);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 1, 0);
        run(30, 1, 0, 0);
        step("walk_h",    1, 0, 1, 0, 8'h22, 8'h58, 8'h30, 2'b01, 0);
        step("walk_h23",  1, 0, 0, 1, 8'h23, 8'h58, 8'h30, 2'b01, 0);
        step("frz_h",     1, 1, 0, 0, 8'h23, 8'h58, 8'h30, 2'b01, 0);
        step("walk_h00",  1, 0, 0, 1, 8'h00, 8'h58, 8'h30, 2'b01, 0);
        step("walk_m",    1, 0, 1, 0, 8'h00, 8'h58, 8'h30, 2'b10, 0);
        step("walk_m59",  1, 0, 0, 1, 8'h00, 8'h59, 8'h30, 2'b10, 0);
        step("walk_m00",  1, 0, 0, 1, 8'h00, 8'h00, 8'h30, 2'b10, 0);
        step("frz_m",     1, 1, 0, 0, 8'h00, 8'h00, 8'h30, 2'b10, 0);
        step("walk_s",    1, 0, 1, 0, 8'h00, 8'h00, 8'h30, 2'b11, 0);
        step("frz_s",     1, 1, 0, 0, 8'h00, 8'h00, 8'h30, 2'b11, 0);
        step("walk_s00",  1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'b11, 0);
        step("walk_run",  1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 2'b00, 0);
        run(5, 1, 0, 0);
        step("mode_tick", 1, 1, 1, 0, 8'h00, 8'h00, 8'h06, 2'b01, 0);
        step("mode_inc",  1, 0, 1, 1, 8'h00, 8'h00, 8'h06, 2'b10, 0);
        step("to_sets2",  1, 0, 1, 0, 8'h00, 8'h00, 8'h06, 2'b11, 0);
        step("sets_mtick", 1, 1, 1, 0, 8'h00, 8'h00, 8'h06, 2'b00, 0);
        cyc(1, 0, 1, 0);
        step("pre_rst",   1, 0, 1, 0, 8'h00, 8'h00, 8'h06, 2'b10, 0);
        step("rst_set",   0, 0, 0, 1, 8'h12, 8'h34, 8'h56, 2'b00, 0);
        step("post_rst",  1, 1, 0, 0, 8'h12, 8'h34, 8'h57, 2'b00, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hms_timekeeper.md
Name: hms_timekeeper

Overview:
- Time-of-day stage directly downstream of the 12-bit tick counter.
- Consumes the counter's one-cycle `carryout` pulse as a 1 Hz `sec_tick`.
- Maintains hours/minutes/seconds in packed BCD.
- Has a button-driven set mode (select field, increment field); its outputs feed the display/segment driver.

Parameters:
- INIT_HOUR, 0, reset hour value (0..23, binary integer, converted to BCD).
- INIT_MIN, 0, reset minute value (0..59).
- INIT_SEC, 0, reset second value (0..59).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- sec_tick  in  1  one-cycle pulse, one per second (from upstream counter carryout).
- mode_btn  in  1  one-cycle pulse (debounced upstream); advances the set-mode state machine.
- inc_btn  in  1  one-cycle pulse; increments the field selected in set mode.
- hour_bcd  out  8  hours, BCD {tens[7:4], units[3:0]}, 00..23.
- min_bcd  out  8  minutes, BCD, 00..59.
- sec_bcd  out  8  seconds, BCD, 00..59.
- set_field  out  2  00=RUN, 01=SET_HOUR, 10=SET_MIN, 11=SET_SEC; drives display blink.
- day_pulse  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover in RUN.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - hour/min/sec = INIT_* in BCD; state RUN; set_field=00; day_pulse=0.
  - Reset overrides all other inputs in that cycle.
  - Reset mid-set-mode returns to RUN with INIT values.
- All outputs are registered. A change caused by an input pulse at edge N is visible after edge N (1-cycle latency).
- State machine, advanced only by mode_btn:
  - RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  - States encoded exactly as set_field.
- RUN state:
  - sec_tick increments seconds.
  - Units digit 9 -> 0 with carry to tens; seconds 59 -> 00 with carry to minutes.
  - Minutes 59 -> 00 with carry to hours; hours 23 -> 00.
  - At 23:59:59 + tick: all fields 00 and day_pulse=1 for exactly that one cycle; otherwise day_pulse=0.
  - inc_btn is ignored.
- Set states:
  - sec_tick is ignored; the clock is frozen.
  - inc_btn increments only the selected field, wrapping without carry:
    - hour 23 -> 00.
    - min 59 -> 00, hour unchanged.
    - sec: inc_btn clears seconds to 00 (resync); it does not increment.
  - day_pulse never asserts in set states.
- Simultaneous events:
  - mode_btn and inc_btn in the same cycle: the state transitions and inc_btn is ignored.
  - mode_btn and sec_tick in RUN in the same cycle: the tick is applied, then the state becomes SET_HOUR.
  - mode_btn and sec_tick in SET_SEC: the tick is dropped and the state returns to RUN.
- Arithmetic:
  - Per-digit BCD; no binary-to-BCD conversion in the datapath.
  - Digits never hold values above 9. Tens digits never exceed 5 (min/sec) or 2 (hour).
  - Hour units is limited to 3 when hour tens is 2.
- Input pulses longer than one cycle are treated as one event per cycle asserted. Upstream guarantees single-cycle pulses.

Test Plan:
- Reset with INIT 12/34/56, then hold rst_n=0 while pulsing sec_tick -> outputs stay 0x12/0x34/0x56, set_field=00, day_pulse=0.
- From 00:00:58, apply 2 sec_ticks -> 00:00:59, then 00:01:00. From 09:59:59, one tick -> 10:00:00.
- From 23:59:59, one sec_tick -> 00:00:00 with day_pulse=1 for exactly one cycle, 0 on the next cycle.
- Set mode walk from 22:58:30:
  - mode_btn -> set_field=01; inc_btn x2 -> hour 0x00.
  - mode_btn -> set_field=10; inc_btn x2 -> min 0x00, hour still 0x00.
  - mode_btn -> set_field=11; inc_btn -> sec 0x00.
  - sec_ticks throughout leave values unchanged.
  - mode_btn -> set_field=00.
- Simultaneity:
  - RUN at 00:00:05, mode_btn with sec_tick -> sec 0x06, set_field=01.
  - SET_HOUR, mode_btn with inc_btn -> set_field=10, hour unchanged.
- Reset asserted while set_field=10 -> set_field=00, INIT values restored next cycle.
